// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl - measurement sequencer for the TDC datapath.
//
// On an arm request the block clears the delay line, launches it, and runs a
// coarse cycle counter until the synchronized stop event or a timeout.  The
// coarse count, fine code and a status byte are then streamed as a 5-byte
// frame (A5, coarse hi, coarse lo, fine, status) over a valid/ready handshake,
// followed by a one-cycle end-of-transmission pulse.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   arm         measurement request (sampled in IDLE only)
//   stop_sync   one-cycle stop event, already synchronous to clk
//   fine_code   delay-line code, valid together with stop_sync
//   tdc_clear   one-cycle delay-line clear
//   tdc_start   one-cycle delay-line launch
//   busy        high in every state except IDLE
//   uart_data   frame byte
//   uart_valid  frame byte valid
//   uart_ready  UART TX accepts the byte
//   eot         one-cycle end-of-transmission pulse
module tdc_meas_ctrl #(
    parameter int unsigned COARSE_W = 16,
    parameter int unsigned FINE_W   = 8,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop_sync,
    input  logic [FINE_W-1:0] fine_code,
    output logic              tdc_clear,
    output logic              tdc_start,
    output logic              busy,
    output logic [7:0]        uart_data,
    output logic              uart_valid,
    input  logic              uart_ready,
    output logic              eot
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SEND,
        S_DONE
    } state_e;

    localparam logic [COARSE_W-1:0] TIMEOUT_C = COARSE_W'(TIMEOUT);
    localparam logic [7:0]          SYNC_BYTE = 8'hA5;

    state_e              state_q, state_d;
    logic [COARSE_W-1:0] cnt_q, cnt_d;
    logic [15:0]         coarse_q, coarse_d;
    logic [7:0]          fine_q, fine_d;
    logic [3:0]          seq_q, seq_d;
    logic                early_q, early_d;
    logic                tmo_q, tmo_d;
    logic [2:0]          idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            coarse_q <= '0;
            fine_q   <= '0;
            seq_q    <= '0;
            early_q  <= 1'b0;
            tmo_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            coarse_q <= coarse_d;
            fine_q   <= fine_d;
            seq_q    <= seq_d;
            early_q  <= early_d;
            tmo_q    <= tmo_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        coarse_d = coarse_q;
        fine_d   = fine_q;
        seq_d    = seq_q;
        early_d  = early_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // The counter is zeroed here so the first RUN cycle sees 0.
                cnt_d   = '0;
                state_d = S_RUN;
                if (stop_sync) begin
                    early_d = 1'b1;
                end
            end
            S_RUN: begin
                // A stop coinciding with the timeout count takes priority.
                if (stop_sync) begin
                    coarse_d = 16'(cnt_q);
                    fine_d   = 8'(fine_code);
                    idx_d    = '0;
                    state_d  = S_SEND;
                end else if (cnt_q == TIMEOUT_C) begin
                    coarse_d = '1;
                    fine_d   = '0;
                    tmo_d    = 1'b1;
                    idx_d    = '0;
                    state_d  = S_SEND;
                end else begin
                    cnt_d = cnt_q + COARSE_W'(1);
                end
            end
            S_SEND: begin
                if (uart_ready) begin
                    if (idx_q == 3'd4) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                seq_d   = seq_q + 4'd1;
                early_d = 1'b0;
                tmo_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic [7:0] frame_byte;

    always_comb begin
        frame_byte = '0;
        case (idx_q)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = coarse_q[15:8];
            3'd2:    frame_byte = coarse_q[7:0];
            3'd3:    frame_byte = fine_q;
            3'd4:    frame_byte = {seq_q, 2'b00, early_q, tmo_q};
            default: frame_byte = '0;
        endcase
    end

    assign tdc_clear  = (state_q == S_CLEAR);
    assign tdc_start  = (state_q == S_RUN) && (cnt_q == '0);
    assign busy       = (state_q != S_IDLE);
    assign uart_valid = (state_q == S_SEND);
    assign uart_data  = (state_q == S_SEND) ? frame_byte : '0;
    assign eot        = (state_q == S_DONE);

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Testbench for tdc_meas_ctrl (TIMEOUT = 100, default widths).
module tb_tdc_meas_ctrl;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm;
    logic       stop_sync;
    logic [7:0] fine_code;
    logic       tdc_clear;
    logic       tdc_start;
    logic       busy;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       uart_ready;
    logic       eot;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_seq = 4'd0;

    tdc_meas_ctrl #(
        .COARSE_W(16),
        .FINE_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .stop_sync (stop_sync),
        .fine_code (fine_code),
        .tdc_clear (tdc_clear),
        .tdc_start (tdc_start),
        .busy      (busy),
        .uart_data (uart_data),
        .uart_valid(uart_valid),
        .uart_ready(uart_ready),
        .eot       (eot)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;          // stop offset after tdc_start, -1 = never
        bit          early;      // extra stop in the CLEAR cycle
        logic [7:0]  fine;
        int          stall_byte; // byte index held off, -1 = none
        int          stall_len;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected frame from the measurement outcome, straight from the frame rules.
    function automatic logic [39:0] model_frame(input int k, input bit early,
                                                input logic [7:0] fine, input logic [3:0] seq);
        logic [15:0] coarse;
        logic [7:0]  f;
        bit          tmo;
        if (k >= 0 && k <= TMO) begin
            coarse = 16'(k);
            f      = fine;
            tmo    = 1'b0;
        end else begin
            coarse = 16'hFFFF;
            f      = 8'h00;
            tmo    = 1'b1;
        end
        return {8'hA5, coarse, f, seq, 2'b00, early, tmo};
    endfunction

    task automatic run_meas(input int k, input bit early, input logic [7:0] fine,
                            input int stall_byte, input int stall_len, input bit rnd_ready,
                            input logic [39:0] exp_frame);
        logic [39:0] got;
        logic [7:0]  prev_data;
        bit          prev_hold;
        bit          seen;
        int          c;
        int          nbytes;
        int          stall_cnt;
        int          cyc;
        int          starts;
        int          exp_lat;
        got = '0;

        @(negedge clk);
        check("idle_busy", {busy, uart_valid, eot}, 3'b000);
        stop_sync = 1'($urandom_range(0, 1));
        fine_code = 8'($urandom);
        arm       = 1'b1;

        @(negedge clk);
        check("clear_cycle", {tdc_clear, tdc_start, busy, uart_valid}, 4'b1010);
        arm       = 1'($urandom_range(0, 1));
        stop_sync = early;
        fine_code = 8'($urandom);

        @(negedge clk);
        check("start_cycle", {tdc_clear, tdc_start, busy}, 3'b011);
        c      = 0;
        seen   = 1'b0;
        starts = 0;
        while (!seen && c <= TMO + 20) begin
            if (uart_valid) begin
                seen = 1'b1;
            end else begin
                if (tdc_start) starts++;
                stop_sync = (c == k);
                fine_code = (c == k) ? fine : 8'($urandom);
                arm       = 1'($urandom_range(0, 1));
                @(negedge clk);
                c++;
            end
        end
        check("start_pulses", starts, 1);
        exp_lat = (k >= 0 && k <= TMO) ? k + 1 : TMO + 1;
        check("valid_latency", c, exp_lat);
        if (!seen) return;

        nbytes    = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        stall_cnt = 0;
        cyc       = 0;
        while (nbytes < 5 && cyc < 200) begin
            if (!uart_valid || eot) begin
                check("send_valid_eot", {uart_valid, eot}, 2'b10);
                break;
            end
            if (prev_hold) check("data_hold", uart_data, prev_data);
            if (nbytes == stall_byte && stall_cnt < stall_len) begin
                uart_ready = 1'b0;
                stall_cnt++;
            end else if (rnd_ready) begin
                uart_ready = ($urandom_range(0, 3) != 0);
            end else begin
                uart_ready = 1'b1;
            end
            stop_sync = 1'($urandom_range(0, 1));
            arm       = 1'($urandom_range(0, 1));
            prev_data = uart_data;
            if (uart_ready) begin
                got       = {got[31:0], uart_data};
                nbytes++;
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check("frame", got, exp_frame);
        check("byte_count", nbytes, 5);
        if (stall_byte >= 0) check("stall_len", stall_cnt, stall_len);

        check("done_cycle", {uart_valid, eot, busy}, 3'b011);
        arm        = 1'b0;
        stop_sync  = 1'($urandom_range(0, 1));
        uart_ready = 1'b1;
        @(negedge clk);
        check("after_done", {eot, busy, uart_valid, tdc_clear}, 4'b0000);
        stop_sync = 1'b0;
        exp_seq   = exp_seq + 4'd1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] ef;
        int          kk;
        bit          ee;
        logic [7:0]  ff;

        vecs[0] = '{37,  1'b0, 8'h5C, -1, 0, 40'hA5_00_25_5C_00};
        vecs[1] = '{-1,  1'b0, 8'h77, -1, 0, 40'hA5_FF_FF_00_11};
        vecs[2] = '{100, 1'b0, 8'h3C, -1, 0, 40'hA5_00_64_3C_20};
        vecs[3] = '{12,  1'b0, 8'h81,  2, 5, 40'hA5_00_0C_81_30};
        vecs[4] = '{50,  1'b1, 8'h07, -1, 0, 40'hA5_00_32_07_42};
        vecs[5] = '{0,   1'b0, 8'hFF, -1, 0, 40'hA5_00_00_FF_50};
        vecs[6] = '{99,  1'b1, 8'h00, -1, 0, 40'hA5_00_63_00_62};

        reset      = 1'b1;
        arm        = 1'b0;
        stop_sync  = 1'b0;
        fine_code  = '0;
        uart_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {tdc_clear, tdc_start, busy, uart_data, uart_valid, eot}, 13'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_meas(vecs[i].k, vecs[i].early, vecs[i].fine,
                     vecs[i].stall_byte, vecs[i].stall_len, 1'b0, vecs[i].exp);
        end

        // Random measurements carry the sequence number through its wrap.
        for (int i = 0; i < 12; i++) begin
            kk = $urandom_range(0, TMO + 15);
            ee = 1'($urandom_range(0, 1));
            ff = 8'($urandom);
            ef = model_frame(kk, ee, ff, exp_seq);
            run_meas(kk, ee, ff, -1, 0, 1'b1, ef);
        end

        // Reset during SEND, right after byte 1 has been accepted.
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
        check("rst_seq_start", tdc_start, 1'b1);
        stop_sync = 1'b1;
        fine_code = 8'h11;
        @(negedge clk);
        stop_sync = 1'b0;
        check("rst_seq_byte0", {uart_valid, uart_data}, {1'b1, 8'hA5});
        uart_ready = 1'b1;
        @(negedge clk);
        check("rst_seq_byte1", {uart_valid, uart_data}, {1'b1, 8'h00});
        uart_ready = 1'b1;
        @(negedge clk);
        check("rst_seq_byte2", {uart_valid, uart_data}, {1'b1, 8'h00});
        uart_ready = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        check("rst_mid_send", {uart_valid, busy, eot, tdc_clear, tdc_start}, 5'b00000);
        reset      = 1'b0;
        uart_ready = 1'b1;
        exp_seq    = 4'd0;
        @(negedge clk);
        check("rst_no_eot", {eot, busy}, 2'b00);

        ff = 8'($urandom);
        run_meas(20, 1'b0, ff, -1, 0, 1'b1, model_frame(20, 1'b0, ff, exp_seq));
        check("post_reset_frame_seq", exp_seq, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
